zycap_pr_sequencer: RTL

//  Sequences partial-reconfiguration transfers through the ZyCAP AXIS mux into ICAP on behalf of up to 4 requesters.

---
 rtl/zycap_pr_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/zycap_pr_sequencer.sv
// Round-robin PR transfer sequencer driving the ZyCAP AXIS mux and ICAP direction, with per-transfer timeout/error status.
// Latency: grant, SETTLE_CYCLES, beats, DRAIN_CYCLES, then 1 RESP cycle; requests stay pending until their req_ready pulse.
module zycap_pr_sequencer #(
  parameter int NUM_REQ        = 4,
  parameter int LEN_WIDTH      = 24,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DRAIN_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           s_axi_lite_aclk,
  input  logic                           s_axi_lite_aresetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len,
  input  logic [NUM_REQ-1:0]             req_rw,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           axis_beat,
  input  logic                           icap_err_status,
  output logic                           done_valid,
  output logic [1:0]                     done_id,
  output logic [1:0]                     done_err,
  output logic                           busy,
  output logic                           zycap_axis_mux_en,
  output logic                           zycap_axis_mux_drop,
  output logic [1:0]                     zycap_axis_mux_sel,
  output logic                           zycap_icap_rw
);

  localparam int PH_MAX = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int IW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] DRAIN_LAST  = PW'(DRAIN_CYCLES - 1);
  localparam logic [IW-1:0] TO_LAST     = IW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STREAM, DRAIN, RESP} state_t;

  state_t               state;
  logic [1:0]           rr_ptr;
  logic [1:0]           gnt_id;
  logic [LEN_WIDTH-1:0] rem;
  logic [PW-1:0]        phase;
  logic [IW-1:0]        idle_cnt;
  logic [1:0]           err_q;

  logic                 gnt_found;
  logic [1:0]           gnt_idx;
  logic [1:0]           rr_next;
  int                   idx;

  // First pending request at or after the round-robin pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = 2'(idx);
      end
    end
  end

  assign rr_next = 2'((int'(gnt_idx) + 1) % NUM_REQ);

  always_ff @(posedge s_axi_lite_aclk) begin
    if (!s_axi_lite_aresetn) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      gnt_id              <= '0;
      rem                 <= '0;
      phase               <= '0;
      idle_cnt            <= '0;
      err_q               <= '0;
      req_ready           <= '0;
      done_valid          <= 1'b0;
      done_id             <= '0;
      done_err            <= '0;
      busy                <= 1'b0;
      zycap_axis_mux_en   <= 1'b0;
      zycap_axis_mux_drop <= 1'b1;
      zycap_axis_mux_sel  <= '0;
      zycap_icap_rw       <= 1'b0;
    end else begin
      req_ready  <= '0;
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            req_ready          <= NUM_REQ'(1) << gnt_idx;
            gnt_id             <= gnt_idx;
            rem                <= req_len[int'(gnt_idx)*LEN_WIDTH +: LEN_WIDTH];
            zycap_icap_rw      <= req_rw[gnt_idx];
            zycap_axis_mux_sel <= gnt_idx;
            rr_ptr             <= rr_next;
            phase              <= '0;
            busy               <= 1'b1;
            state              <= SETUP;
          end
        end
        SETUP: begin
          if (phase == SETTLE_LAST) begin
            phase <= '0;
            if (rem == '0) begin
              err_q <= 2'b00;
              state <= DRAIN;
            end else begin
              idle_cnt            <= '0;
              zycap_axis_mux_en   <= 1'b1;
              zycap_axis_mux_drop <= 1'b0;
              state               <= STREAM;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        STREAM: begin
          // ICAP error outranks a coincident final beat or timeout.
          if (icap_err_status) begin
            err_q               <= 2'b01;
            zycap_axis_mux_en   <= 1'b0;
            zycap_axis_mux_drop <= 1'b1;
            state               <= DRAIN;
          end else if (axis_beat) begin
            rem      <= rem - 1'b1;
            idle_cnt <= '0;
            if (rem == LEN_WIDTH'(1)) begin
              err_q               <= 2'b00;
              zycap_axis_mux_en   <= 1'b0;
              zycap_axis_mux_drop <= 1'b1;
              state               <= DRAIN;
            end
          end else if (idle_cnt == TO_LAST) begin
            err_q               <= 2'b10;
            zycap_axis_mux_en   <= 1'b0;
            zycap_axis_mux_drop <= 1'b1;
            state               <= DRAIN;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (phase == DRAIN_LAST) begin
            phase      <= '0;
            done_valid <= 1'b1;
            done_id    <= gnt_id;
            done_err   <= err_q;
            state      <= RESP;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
